noc_switch_arbiter: RTL and testbench
=====================================

Name: noc_switch_arbiter

Overview:
- Per-router switch allocator for the 5-port mesh router (N, S, W, E, Local).
- Takes each input buffer's head-flit route direction, as computed by the YX route processor, and arbitrates each output port among competing inputs with round-robin priority.
- Locks each output to its winner for a whole wormhole packet, head flit through tail flit.
- Drives crossbar select, output valid, and per-input grant (pop) signals.

Parameters:
- NUM_PORTS, 5, number of router ports; fixed at 5; the direction encoding depends on it.
- DIR_W, 3, width of a route direction code.
- IDX_W, 3, width of an input-index select.

Ports:
- clk_i  input  1  router clock.
- rst_i  input  1  asynchronous, active-high reset.
- req_valid_i  input  5  input buffer i has a flit at its head.
- req_head_i  input  5  head flit of input i is a packet header.
- req_tail_i  input  5  head flit of input i is a packet tail; head and tail both set = single-flit packet.
- req_dir_i  input  15  3-bit route direction per input ([3i+2:3i]); meaningful only when valid and head are set.
- out_ready_i  input  5  downstream of output o can accept a flit this cycle.
- out_valid_o  output  5  output o carries a flit this cycle.
- xbar_sel_o  output  15  3-bit input index driving output o ([3o+2:3o]).
- grant_o  output  5  flit of input i transferred this cycle; input i pops its buffer.
- route_err_o  output  1  pulses when any valid header carries an illegal direction.

Behaviour:
- Direction codes:
  - 000 N, 001 S, 010 W, 011 E, 100 Local; output index equals the code.
  - Codes 101, 110 and 111 are illegal.
- Per-output FSM, one instance per output o, with state registers {state, owner[2:0], rr_ptr[2:0]}.
- IDLE:
  - Candidates are inputs i with valid[i] & head[i] & dir[i]==o.
  - Winner is the first candidate found scanning cyclically from rr_ptr.
  - If a winner exists: next edge -> LOCKED, owner=winner.
  - No transfer ever occurs in IDLE; out_valid_o[o]=0, xbar_sel_o[o]=0.
- LOCKED:
  - xbar_sel_o[o]=owner and out_valid_o[o]=req_valid_i[owner], both combinational.
  - Transfer condition: out_valid_o[o] & out_ready_i[o]; grant_o[owner]=1 in that cycle.
  - Transfer of a flit with tail set: next edge -> IDLE and rr_ptr=(owner+1) mod 5.
  - Otherwise stay LOCKED. Owner bubbles (valid low) hold the lock; no timeout.
- Latency:
  - Header visible in cycle N -> lock at edge ending N -> earliest transfer in cycle N+1.
  - A single-flit packet therefore occupies the output for 2 cycles minimum.
  - Back-to-back body flits transfer 1 per cycle while out_ready_i is high.
- One input targets at most one output at a time, so grant_o[i] is the OR of each output's grant for i, with at most one term active.
  - Assertion: no two outputs LOCKED on the same owner.
- An input already owned by an output is excluded from other outputs' candidate sets, even if its current flit has head set. This guards against a malformed stream.
- Illegal direction:
  - Header never becomes a candidate; route_err_o=1 in every cycle it is presented.
  - The input stalls; recovery is a system-level concern.
- Simultaneous events:
  - An output may release (tail transfer) and re-arbitrate in the same cycle. The new lock is taken at the edge after release, which gives one idle cycle; the released owner's next header competes normally.
  - U-turn (input i routed to output i, e.g. Local->Local) is legal and arbitrated like any other request.
- Reset, asserted at any time, including mid-packet:
  - All FSMs -> IDLE, owner=0, rr_ptr=0.
  - Outputs in reset: out_valid_o=0, grant_o=0, xbar_sel_o=0, route_err_o=0.
  - Partially forwarded packets are abandoned.
- route_err_o is combinational from the inputs, gated to 0 while rst_i is high.

Decomposition:
- Package noc_pkg:
  - dir_e enum (DIR_N=0, DIR_S=1, DIR_W=2, DIR_E=3, DIR_L=4).
  - NUM_PORTS, DIR_W, IDX_W constants.
  - Helper function is_legal_dir.
- Sub-module rr_out_arbiter: one output's FSM, round-robin pick and lock, instantiated 5x via generate.
- The top level does request masking, grant OR-reduction and error detection.

Test Plan:
- Single request: input 2 header dir=011, 3-flit packet, out_ready all high -> out_valid_o[3] in cycles 1,2,3; xbar_sel_o[3]=2; grant_o[2] pulses 3x; FSM back to IDLE after cycle 3.
- Contention: inputs 0, 1 and 4 present headers dir=100 in the same cycle, rr_ptr=0, single-flit packets -> served in order 0,1,4; rr_ptr ends at 0; each packet takes 2 cycles.
- Backpressure: locked packet with out_ready_i[1]=0 for 4 cycles mid-packet -> no grant, out_valid_o[1] held high, lock held; transfer resumes on the first ready cycle.
- Parallel outputs: input 0 ->011 and input 3 ->000 simultaneously -> both outputs locked in the same cycle; grants independent.
- Illegal route: input 1 header dir=111 -> route_err_o=1 each cycle; never granted; other inputs unaffected.
- Reset mid-packet: assert rst_i after the 2nd of 4 flits -> all outputs 0 immediately; after release, a fresh header from input 0 is arbitrated with rr_ptr=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and helpers for the 5-port mesh router switch allocator.
package noc_pkg;

   localparam int NUM_PORTS = 5;
   localparam int DIR_W     = 3;
   localparam int IDX_W     = 3;
   localparam int SUM_W     = IDX_W + 1;

   // Route direction codes; the output port index equals the code.
   // Members are spelled out so West does not collide with the DIR_W width constant.
   typedef enum logic [DIR_W-1:0] {
      DIR_NORTH = 3'd0,
      DIR_SOUTH = 3'd1,
      DIR_WEST  = 3'd2,
      DIR_EAST  = 3'd3,
      DIR_LOCAL = 3'd4
   } dir_e;

   // Per-output allocator states
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Codes above Local (101, 110, 111) do not name a port
   function automatic logic is_legal_dir(input logic [DIR_W-1:0] dir);
      return (dir <= DIR_LOCAL);
   endfunction

   // Port index addition modulo NUM_PORTS; both operands are already below NUM_PORTS
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] step);
      logic [SUM_W-1:0] sum;
      sum = {1'b0, base} + {1'b0, step};
      if (sum >= SUM_W'(NUM_PORTS)) begin
         sum = sum - SUM_W'(NUM_PORTS);
      end
      return sum[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/rr_out_arbiter.sv
// One output port's allocator: round-robin pick among candidate inputs, then
// hold the lock on the winner until its tail flit has been transferred.
module rr_out_arbiter
   import noc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] cand,
   input  logic [NUM_PORTS-1:0] req_valid,
   input  logic [NUM_PORTS-1:0] req_tail,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [IDX_W-1:0]     xbar_sel,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 locked,
   output logic [IDX_W-1:0]     owner
);

   logic [0:0]       state_q;
   logic [IDX_W-1:0] owner_q;
   logic [IDX_W-1:0] rr_q;
   logic             pick_found;
   logic [IDX_W-1:0] pick_idx;
   logic             xfer;

   assign locked    = (state_q == ST_LOCKED);
   assign owner     = owner_q;
   assign out_valid = locked & req_valid[owner_q];
   assign xbar_sel  = locked ? owner_q : '0;
   assign xfer      = out_valid & out_ready;

   // First candidate found scanning cyclically upward from the round-robin pointer
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!pick_found && cand[wrap_add(rr_q, IDX_W'(k))]) begin
            pick_found = 1'b1;
            pick_idx   = wrap_add(rr_q, IDX_W'(k));
         end
      end
   end

   // Pop the owner's buffer on every flit that actually crosses the switch
   always_comb begin
      grant = '0;
      if (xfer) begin
         grant[owner_q] = 1'b1;
      end
   end

   // Lock on a winner, release after the tail transfer and move priority past it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         rr_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_found) begin
                  state_q <= ST_LOCKED;
                  owner_q <= pick_idx;
               end
            end
            ST_LOCKED: begin
               if (xfer && req_tail[owner_q]) begin
                  state_q <= ST_IDLE;
                  rr_q    <= wrap_add(owner_q, IDX_W'(1));
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/noc_switch_arbiter.sv
// Switch allocator for the 5-port mesh router: builds each output's candidate
// set from the head-flit routes, runs one round-robin lock per output and
// merges the per-output grants into per-input pops.
module noc_switch_arbiter
   import noc_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_PORTS-1:0]       req_valid_i,
   input  logic [NUM_PORTS-1:0]       req_head_i,
   input  logic [NUM_PORTS-1:0]       req_tail_i,
   input  logic [NUM_PORTS*DIR_W-1:0] req_dir_i,
   input  logic [NUM_PORTS-1:0]       out_ready_i,
   output logic [NUM_PORTS-1:0]       out_valid_o,
   output logic [NUM_PORTS*IDX_W-1:0] xbar_sel_o,
   output logic [NUM_PORTS-1:0]       grant_o,
   output logic                       route_err_o
);

   logic [NUM_PORTS-1:0] hdr_legal;
   logic [NUM_PORTS-1:0] hdr_illegal;
   logic [NUM_PORTS-1:0] owned;
   logic [NUM_PORTS-1:0] locked;
   logic [IDX_W-1:0]     owner    [NUM_PORTS];
   logic [NUM_PORTS-1:0] lock_map [NUM_PORTS];
   logic [NUM_PORTS-1:0] cand     [NUM_PORTS];
   logic [NUM_PORTS-1:0] grant_per[NUM_PORTS];

   // Classify each presented header as routable or carrying an illegal code
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         hdr_legal[i]   = req_valid_i[i] & req_head_i[i] &  is_legal_dir(req_dir_i[DIR_W*i +: DIR_W]);
         hdr_illegal[i] = req_valid_i[i] & req_head_i[i] & ~is_legal_dir(req_dir_i[DIR_W*i +: DIR_W]);
      end
   end

   // Which outputs currently hold each input; an owned input may not bid elsewhere
   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         for (int o = 0; o < NUM_PORTS; o++) begin
            lock_map[i][o] = locked[o] & (owner[o] == IDX_W'(i));
         end
         owned[i] = |lock_map[i];
      end
   end

   // Candidate set per output: free, legal headers routed to that output
   always_comb begin
      for (int o = 0; o < NUM_PORTS; o++) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            cand[o][i] = hdr_legal[i] & ~owned[i] & (req_dir_i[DIR_W*i +: DIR_W] == DIR_W'(o));
         end
      end
   end

   // An input is locked by at most one output, so the OR never merges two grants
   always_comb begin
      grant_o = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         grant_o = grant_o | grant_per[o];
      end
   end

   assign route_err_o = ~rst_i & (|hdr_illegal);

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
      rr_out_arbiter u_arb (
         .clk       (clk_i),
         .rst       (rst_i),
         .cand      (cand[o]),
         .req_valid (req_valid_i),
         .req_tail  (req_tail_i),
         .out_ready (out_ready_i[o]),
         .out_valid (out_valid_o[o]),
         .xbar_sel  (xbar_sel_o[IDX_W*o +: IDX_W]),
         .grant     (grant_per[o]),
         .locked    (locked[o]),
         .owner     (owner[o])
      );
   end

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chk
      a_single_owner: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(lock_map[i]));
   end

endmodule

// File: tb/tb_noc_switch_arbiter.sv
// Bench for the switch allocator: per-input flit queues feed the DUT, and a
// packet-level model of output ownership predicts every output each cycle.
module tb_noc_switch_arbiter;

   typedef struct packed {
      logic       head;
      logic       tail;
      logic [2:0] dir;
   } flit_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [4:0]  req_valid_i;
   logic [4:0]  req_head_i;
   logic [4:0]  req_tail_i;
   logic [14:0] req_dir_i;
   logic [4:0]  out_ready_i;
   logic [4:0]  out_valid_o;
   logic [14:0] xbar_sel_o;
   logic [4:0]  grant_o;
   logic        route_err_o;

   flit_t fifo_q [5][$];
   int    m_owner[5];
   int    m_rr[5];
   int    m_next_owner[5];
   int    m_next_rr[5];
   int    glog_in[5][$];
   int    glog_cyc[5][$];
   int    cyc = 0;
   int    err_seen = 0;
   int    n_checks = 0;
   int    n_fails = 0;

   logic [4:0]  exp_valid;
   logic [4:0]  exp_grant;
   logic [14:0] exp_sel;
   logic        exp_err;

   noc_switch_arbiter dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (req_valid_i),
      .req_head_i  (req_head_i),
      .req_tail_i  (req_tail_i),
      .req_dir_i   (req_dir_i),
      .out_ready_i (out_ready_i),
      .out_valid_o (out_valid_o),
      .xbar_sel_o  (xbar_sel_o),
      .grant_o     (grant_o),
      .route_err_o (route_err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pushPacket(input int i, input int len, input logic [2:0] dir);
      for (int k = 0; k < len; k++) begin
         flit_t f;
         f.head = (k == 0);
         f.tail = (k == len - 1);
         f.dir  = (k == 0) ? dir : 3'($urandom_range(7));
         fifo_q[i].push_back(f);
      end
   endtask

   task automatic clearLogs();
      for (int o = 0; o < 5; o++) begin
         glog_in[o].delete();
         glog_cyc[o].delete();
      end
   endtask

   task automatic applyStimulus(input logic [4:0] rdy, input int vpct);
      for (int i = 0; i < 5; i++) begin
         if (fifo_q[i].size() > 0 && $urandom_range(99) < vpct) begin
            req_valid_i[i]       = 1'b1;
            req_head_i[i]        = fifo_q[i][0].head;
            req_tail_i[i]        = fifo_q[i][0].tail;
            req_dir_i[3*i +: 3]  = fifo_q[i][0].dir;
         end else begin
            req_valid_i[i]       = 1'b0;
            req_head_i[i]        = 1'($urandom_range(1));
            req_tail_i[i]        = 1'($urandom_range(1));
            req_dir_i[3*i +: 3]  = 3'($urandom_range(7));
         end
      end
      out_ready_i = rdy;
   endtask

   // Packet-level ownership model: an output either belongs to one input until
   // that input's tail leaves, or is free and hands itself to the next bidder
   // in cyclic order after the last input it served.
   task automatic modelEval();
      exp_valid = '0;
      exp_sel   = '0;
      exp_grant = '0;
      exp_err   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (req_valid_i[i] && req_head_i[i] && req_dir_i[3*i +: 3] > 3'd4) exp_err = 1'b1;
      end
      for (int o = 0; o < 5; o++) begin
         m_next_owner[o] = m_owner[o];
         m_next_rr[o]    = m_rr[o];
         if (m_owner[o] >= 0) begin
            int w;
            w = m_owner[o];
            exp_sel[3*o +: 3] = w[2:0];
            exp_valid[o]      = req_valid_i[w];
            if (req_valid_i[w] && out_ready_i[o]) begin
               exp_grant[w] = 1'b1;
               glog_in[o].push_back(w);
               glog_cyc[o].push_back(cyc);
               if (req_tail_i[w]) begin
                  m_next_owner[o] = -1;
                  m_next_rr[o]    = (w + 1) % 5;
               end
            end
         end else begin
            bit found;
            found = 0;
            for (int k = 0; k < 5; k++) begin
               int  i;
               bit  busy;
               i    = (m_rr[o] + k) % 5;
               busy = 0;
               for (int p = 0; p < 5; p++) if (m_owner[p] == i) busy = 1;
               if (!found && !busy && req_valid_i[i] && req_head_i[i] &&
                   int'(req_dir_i[3*i +: 3]) == o) begin
                  found           = 1;
                  m_next_owner[o] = i;
               end
            end
         end
      end
   endtask

   task automatic checkOutput();
      checkVal("out_valid", 32'(out_valid_o), 32'(exp_valid));
      checkVal("xbar_sel",  32'(xbar_sel_o),  32'(exp_sel));
      checkVal("grant",     32'(grant_o),     32'(exp_grant));
      checkVal("route_err", 32'(route_err_o), 32'(exp_err));
      if (route_err_o) err_seen++;
   endtask

   task automatic stepCycle(input logic [4:0] rdy, input int vpct);
      applyStimulus(rdy, vpct);
      @(negedge clk_i);
      modelEval();
      checkOutput();
      @(posedge clk_i);
      for (int o = 0; o < 5; o++) begin
         m_owner[o] = m_next_owner[o];
         m_rr[o]    = m_next_rr[o];
      end
      for (int i = 0; i < 5; i++) begin
         if (exp_grant[i]) void'(fifo_q[i].pop_front());
      end
      cyc++;
      #1;
   endtask

   task automatic doReset();
      rst_i       = 1'b1;
      req_valid_i = '1;
      req_head_i  = '1;
      req_tail_i  = '0;
      req_dir_i   = '1;
      out_ready_i = '1;
      #1;
      checkVal("reset out_valid", 32'(out_valid_o), 32'd0);
      checkVal("reset grant",     32'(grant_o),     32'd0);
      checkVal("reset xbar_sel",  32'(xbar_sel_o),  32'd0);
      checkVal("reset route_err", 32'(route_err_o), 32'd0);
      for (int i = 0; i < 5; i++) begin
         fifo_q[i].delete();
         m_owner[i] = -1;
         m_rr[i]    = 0;
      end
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   task automatic checkLog(input string name, input int o, input int n,
                           input int ein[3], input int ecyc[3]);
      checkVal({name, " count"}, 32'(glog_in[o].size()), 32'(n));
      for (int k = 0; k < n; k++) begin
         if (k < glog_in[o].size()) begin
            checkVal({name, " input"}, 32'(glog_in[o][k]),  32'(ein[k]));
            checkVal({name, " cycle"}, 32'(glog_cyc[o][k]), 32'(ecyc[k]));
         end
      end
   endtask

   initial begin
      int c0;
      int guard;
      int total;
      logic [4:0] rdy;

      doReset();

      // Single 3-flit packet, input 2 to East
      clearLogs();
      pushPacket(2, 3, 3'd3);
      c0 = cyc;
      repeat (6) stepCycle(5'b11111, 100);
      checkLog("single", 3, 3, '{2, 2, 2}, '{c0 + 1, c0 + 2, c0 + 3});
      checkVal("single released", 32'(m_owner[3]), 32'hffff_ffff);

      // Three single-flit packets contending for Local
      doReset();
      clearLogs();
      pushPacket(0, 1, 3'd4);
      pushPacket(1, 1, 3'd4);
      pushPacket(4, 1, 3'd4);
      c0 = cyc;
      repeat (8) stepCycle(5'b11111, 100);
      checkLog("contention", 4, 3, '{0, 1, 4}, '{c0 + 1, c0 + 3, c0 + 5});
      checkVal("contention rr", 32'(m_rr[4]), 32'd0);

      // Backpressure on South for 4 cycles after the first flit
      clearLogs();
      pushPacket(3, 3, 3'd1);
      c0 = cyc;
      for (int k = 0; k < 10; k++) begin
         rdy = (k >= 2 && k <= 5) ? 5'b11101 : 5'b11111;
         stepCycle(rdy, 100);
      end
      checkLog("backpressure", 1, 3, '{3, 3, 3}, '{c0 + 1, c0 + 6, c0 + 7});

      // Two outputs locked in the same cycle
      clearLogs();
      pushPacket(0, 2, 3'd3);
      pushPacket(3, 2, 3'd0);
      c0 = cyc;
      repeat (5) stepCycle(5'b11111, 100);
      checkLog("parallel east", 3, 2, '{0, 0, 0}, '{c0 + 1, c0 + 2, 0});
      checkLog("parallel north", 0, 2, '{3, 3, 0}, '{c0 + 1, c0 + 2, 0});

      // Illegal route on input 1 while input 2 goes to Local
      clearLogs();
      pushPacket(1, 1, 3'd7);
      pushPacket(2, 1, 3'd4);
      err_seen = 0;
      c0 = cyc;
      repeat (5) stepCycle(5'b11111, 100);
      checkVal("illegal err cycles", 32'(err_seen), 32'd5);
      checkVal("illegal stuck", 32'(fifo_q[1].size()), 32'd1);
      checkLog("illegal other", 4, 1, '{2, 0, 0}, '{c0 + 1, 0, 0});

      // Reset in the middle of a 4-flit packet, pointer on North moved to 1 first
      doReset();
      clearLogs();
      pushPacket(0, 1, 3'd0);
      pushPacket(0, 4, 3'd0);
      guard = 0;
      while (glog_in[0].size() < 3 && guard < 30) begin
         stepCycle(5'b11111, 100);
         guard++;
      end
      checkVal("midpkt progress", 32'(glog_in[0].size()), 32'd3);
      doReset();
      clearLogs();
      pushPacket(0, 1, 3'd0);
      pushPacket(4, 1, 3'd0);
      c0 = cyc;
      repeat (6) stepCycle(5'b11111, 100);
      checkLog("post reset", 0, 2, '{0, 4, 0}, '{c0 + 1, c0 + 3, 0});

      // Random traffic with bubbles and random backpressure
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 5; i++) begin
            if (fifo_q[i].size() == 0 && $urandom_range(3) == 0) begin
               pushPacket(i, int'($urandom_range(1, 4)), 3'($urandom_range(4)));
            end
         end
         for (int o = 0; o < 5; o++) rdy[o] = ($urandom_range(3) != 0);
         stepCycle(rdy, 80);
      end
      guard = 0;
      total = 1;
      while (total > 0 && guard < 400) begin
         stepCycle(5'b11111, 100);
         guard++;
         total = 0;
         for (int i = 0; i < 5; i++) total += fifo_q[i].size();
      end
      checkVal("drain empty", 32'(total), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
